// File: rtl/mux8_rr_arb.sv
// mux8_rr_arb: round-robin grant and registered select for the 8:1 output mux slices
module mux8_rr_arb #(
    parameter int unsigned MAX_BEATS = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_req_vld,
    input  logic [7:0] i_req_last,
    output logic [7:0] o_req_rdy,
    output logic [2:0] o_sel,
    output logic [7:0] o_gnt,
    output logic       o_vld,
    output logic       o_last,
    input  logic       i_rdy,
    output logic       o_busy
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nx;
    logic [2:0]  ptr, ptr_nx, sel_nx, win;
    logic [7:0]  gnt_nx;
    logic [15:0] cnt, cnt_nx;
    logic        xfer, lim, rel;

    assign o_busy    = state == BUSY;
    assign o_vld     = o_busy & i_req_vld[o_sel];
    assign o_last    = o_busy & i_req_last[o_sel];
    assign o_req_rdy = o_gnt & {8{i_rdy}};
    assign xfer      = o_vld & i_rdy;
    assign lim       = (MAX_BEATS != 0) && (cnt + 16'd1 == 16'(MAX_BEATS));
    assign rel       = xfer & (o_last | lim);

    // first requesting index at or after ptr; scanning downward lets the nearest one win
    always_comb begin
        win = ptr;
        for (int k = 7; k >= 0; k--)
            if (i_req_vld[ptr + 3'(k)]) win = ptr + 3'(k);
    end

    // grant on request in IDLE, count beats and release on last or beat limit in BUSY
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        sel_nx   = o_sel;
        gnt_nx   = o_gnt;
        if (state == IDLE) begin
            if (|i_req_vld) begin
                state_nx = BUSY;
                sel_nx   = win;
                gnt_nx   = 8'd1 << win;
                cnt_nx   = '0;
            end
        end else if (rel) begin
            state_nx = IDLE;
            ptr_nx   = o_sel + 3'd1;
            sel_nx   = '0;
            gnt_nx   = '0;
            cnt_nx   = '0;
        end else if (xfer) begin
            cnt_nx = cnt + 16'd1;
        end
    end

    // state, priority pointer, beat count and the registered select/grant
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            o_sel <= '0;
            o_gnt <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
            o_sel <= sel_nx;
            o_gnt <= gnt_nx;
        end
    end
endmodule

// File: tb/tb_mux8_rr_arb.sv
// tb_mux8_rr_arb: scoreboard bench for an unlimited and a 3-beat-limited arbiter
module tb_mux8_rr_arb;
    typedef struct packed {
        logic       busy;
        logic [2:0] g;
        logic [2:0] ptr;
        logic [15:0] beats;
    } mst_t;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       busy;
        logic       vld;
        logic       last;
        logic [7:0] rdy;
    } obs_t;

    logic       clk, reset, i_rdy;
    logic [7:0] i_req_vld, i_req_last;
    logic [2:0] sel [2];
    logic [7:0] gnt [2];
    logic [7:0] rrdy [2];
    logic       busy [2];
    logic       ovld [2];
    logic       olast [2];

    int   nchk = 0, npass = 0;
    obs_t q [2][$];
    mst_t m [2];
    bit   known = 0;
    obs_t e, g;
    int   w [2][8];
    logic pbusy [2];
    logic [7:0] pv = '0;
    logic prst = 1'b1;

    mux8_rr_arb #(.MAX_BEATS(0)) dut0 (
        .clk(clk), .reset(reset), .i_req_vld(i_req_vld), .i_req_last(i_req_last),
        .o_req_rdy(rrdy[0]), .o_sel(sel[0]), .o_gnt(gnt[0]), .o_vld(ovld[0]),
        .o_last(olast[0]), .i_rdy(i_rdy), .o_busy(busy[0])
    );

    mux8_rr_arb #(.MAX_BEATS(3)) dut3 (
        .clk(clk), .reset(reset), .i_req_vld(i_req_vld), .i_req_last(i_req_last),
        .o_req_rdy(rrdy[1]), .o_sel(sel[1]), .o_gnt(gnt[1]), .o_vld(ovld[1]),
        .o_last(olast[1]), .i_rdy(i_rdy), .o_busy(busy[1])
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    endtask

    // outputs the arbiter must show this cycle, given who holds the grant
    function automatic obs_t expect_out(mst_t s, logic [7:0] v, logic [7:0] l, logic rd);
        obs_t o = '0;
        if (s.busy) begin
            o.sel  = s.g;
            o.gnt  = 8'd1 << s.g;
            o.busy = 1'b1;
            o.vld  = v[s.g];
            o.last = l[s.g];
            o.rdy  = rd ? 8'd1 << s.g : 8'd0;
        end
        return o;
    endfunction

    // who holds the grant after this clock edge
    function automatic mst_t advance(mst_t s, int lim, logic r, logic [7:0] v, logic [7:0] l, logic rd);
        mst_t n = s;
        if (r) return '0;
        if (!s.busy) begin
            for (int k = 0; k < 8; k++)
                if (v[(int'(s.ptr) + k) % 8]) begin
                    n.busy  = 1'b1;
                    n.g     = 3'((int'(s.ptr) + k) % 8);
                    n.beats = '0;
                    break;
                end
        end else if (v[s.g] && rd) begin
            n.beats = s.beats + 16'd1;
            if (l[s.g] || (lim != 0 && int'(n.beats) == lim)) begin
                n.busy = 1'b0;
                n.ptr  = 3'((int'(s.g) + 1) % 8);
            end
        end
        return n;
    endfunction

    task automatic cyc(input logic r, input logic [7:0] v, input logic [7:0] l, input logic rd);
        @(negedge clk);
        reset = r; i_req_vld = v; i_req_last = l; i_rdy = rd;
        for (int i = 0; i < 2; i++) begin
            if (known) q[i].push_back(expect_out(m[i], v, l, rd));
            m[i] = advance(m[i], i == 0 ? 0 : 3, r, v, l, rd);
        end
        if (r) known = 1;
    endtask

    always @(negedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            if (q[i].size() != 0) begin
                e = q[i].pop_front();
                g.sel = sel[i]; g.gnt = gnt[i]; g.busy = busy[i];
                g.vld = ovld[i]; g.last = olast[i]; g.rdy = rrdy[i];
                chk($sformatf("outputs_dut%0d", i), 32'(g), 32'(e));
                chk($sformatf("onehot_rdy_dut%0d", i), 32'($countones(rrdy[i]) <= 1), 32'd1);
                if (prst) begin
                    for (int r = 0; r < 8; r++) w[i][r] = 0;
                end else if (busy[i] && !pbusy[i]) begin
                    for (int r = 0; r < 8; r++)
                        if (r == int'(sel[i])) w[i][r] = 0;
                        else if (pv[r]) begin
                            w[i][r]++;
                            chk($sformatf("bounded_wait_dut%0d_req%0d", i, r), 32'(w[i][r] <= 7), 32'd1);
                        end else w[i][r] = 0;
                end
                pbusy[i] = busy[i];
            end
        end
        pv   = i_req_vld;
        prst = reset;
    end

    localparam bit RP [12] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

    initial begin
        int left, nx, sel_bad;
        logic [7:0] v, l;
        reset = 1; i_req_vld = 0; i_req_last = 0; i_rdy = 0;
        pbusy[0] = 0; pbusy[1] = 0;
        m[0] = '0; m[1] = '0;
        // reset, then one single-beat request from requester 4
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(0, 8'h10, 8'h10, 1); #2;
        for (int i = 0; i < 2; i++) begin
            chk("reset_gnt", 32'(gnt[i]), 0);
            chk("reset_sel", 32'(sel[i]), 0);
            chk("reset_busy", 32'(busy[i]), 0);
            chk("reset_req_rdy", 32'(rrdy[i]), 0);
            chk("reset_vld", 32'(ovld[i]), 0);
        end
        cyc(0, 8'h10, 8'h10, 1); #2;
        for (int i = 0; i < 2; i++) begin
            chk("single_gnt", 32'(gnt[i]), 32'h10);
            chk("single_sel", 32'(sel[i]), 4);
            chk("single_req_rdy", 32'(rrdy[i]), 32'h10);
        end
        cyc(0, 0, 0, 1); #2;
        for (int i = 0; i < 2; i++) chk("single_idle", 32'(busy[i]), 0);
        cyc(0, 8'hff, 8'hff, 1);
        cyc(0, 8'hff, 8'hff, 1); #2;
        for (int i = 0; i < 2; i++) chk("single_ptr_next", 32'(sel[i]), 5);
        // fairness: everyone requesting one-beat packets
        cyc(1, 0, 0, 1);
        for (int c = 0; c < 18; c++) begin
            cyc(0, 8'hff, 8'hff, 1); #2;
            for (int i = 0; i < 2; i++) begin
                chk("fair_busy", 32'(busy[i]), 32'(c % 2));
                if (c % 2 == 1) chk("fair_sel", 32'(sel[i]), 32'((c / 2) % 8));
            end
        end
        // backpressure and a withdrawn valid on a 4-beat packet from requester 2
        cyc(1, 0, 0, 1);
        left = 4; nx = 0; sel_bad = 0;
        for (int c = 0; c < 12; c++) begin
            v = (c != 4 && left > 0) ? 8'h04 : 8'h00;
            l = (left == 1) ? 8'h04 : 8'h00;
            cyc(0, v, l, RP[c]); #2;
            if (busy[0] && sel[0] != 3'd2) sel_bad++;
            if (c == 7) chk("bp_busy_on_last", 32'(busy[0]), 1);
            if (c == 8) chk("bp_released", 32'(busy[0]), 0);
            if (gnt[0][2] && v[2] && RP[c]) begin nx++; left--; end
        end
        chk("bp_xfers", 32'(nx), 4);
        chk("bp_sel_stable", 32'(sel_bad), 0);
        // beat limit: requester 6 streams without last, requester 1 waits
        cyc(1, 0, 0, 1);
        cyc(0, 8'h40, 0, 1);
        for (int c = 1; c <= 8; c++) begin
            cyc(0, 8'h42, 8'h02, 1); #2;
            if (c == 3) chk("lim_sel6", 32'({busy[1], sel[1]}), 32'hE);
            if (c == 4) chk("lim_release", 32'(busy[1]), 0);
            if (c == 5) chk("lim_wrap_sel1", 32'(sel[1]), 1);
            if (c == 6) chk("lim_release1", 32'(busy[1]), 0);
            if (c == 7) chk("lim_regrant6", 32'(sel[1]), 6);
            if (c == 7) chk("nolim_hold6", 32'({busy[0], sel[0]}), 32'hE);
        end
        // reset during beat 2 of a packet from requester 3
        cyc(1, 0, 0, 1);
        cyc(0, 8'h08, 0, 1);
        cyc(0, 8'h08, 0, 1);
        cyc(1, 8'h08, 0, 1);
        cyc(0, 8'hff, 8'hff, 1); #2;
        for (int i = 0; i < 2; i++) begin
            chk("rstmid_gnt", 32'(gnt[i]), 0);
            chk("rstmid_busy", 32'(busy[i]), 0);
            chk("rstmid_req_rdy", 32'(rrdy[i]), 0);
        end
        cyc(0, 8'hff, 8'hff, 1); #2;
        for (int i = 0; i < 2; i++) chk("rstmid_first_gnt", 32'(gnt[i]), 1);
        // random regression
        for (int c = 0; c < 10000; c++)
            cyc($urandom_range(0, 499) == 0, 8'($urandom), 8'($urandom & $urandom), $urandom_range(0, 3) != 0);
        cyc(0, 0, 0, 1);
        @(negedge clk); #3;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/mux8_rr_arb.md
# mux8_rr_arb

Round-robin arbiter and sequencer for the 8:1 select datapath in the vector-add CAE. Eight requesters each offer a packet stream. The block grants one requester at a time, drives a registered 3-bit select to every 8:1 mux slice in the output path, and holds the grant until the packet's last beat is accepted or an optional beat limit is reached. The muxed data path stays outside this block; only the select lines and the handshake are produced here.

## Interface
- MAX_BEATS, 0, beats accepted before forced grant release; 0 disables the limit (release on last only); legal range 0..65535
- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- i_req_vld  in  8  per-requester beat valid
- i_req_last  in  8  per-requester last-beat flag, qualified by i_req_vld
- o_req_rdy  out  8  per-requester beat accepted; at most one bit set
- o_sel  out  3  registered select to the 8:1 mux slices; the binary index of the granted requester
- o_gnt  out  8  registered one-hot grant; all zero when idle
- o_vld  out  1  muxed beat valid to downstream
- o_last  out  1  muxed last flag, qualified by o_vld
- i_rdy  in  1  downstream ready
- o_busy  out  1  grant held (state BUSY)

## Operation
- States: IDLE and BUSY. Internal registers: ptr[2:0] (next priority index), beat counter cnt[15:0].
- IDLE:
  - If i_req_vld != 0, select the winner: the first index with i_req_vld set, searching ptr, ptr+1, … mod 8.
  - Register o_sel = winner, o_gnt = 1<<winner, cnt = 0, and go to BUSY.
  - If i_req_vld == 0, stay in IDLE.
- BUSY, combinational outputs:
  - o_vld = i_req_vld[o_sel]
  - o_last = i_req_last[o_sel]
  - o_req_rdy = o_gnt & {8{i_rdy}}
- A transfer is o_vld && i_rdy. On each transfer, cnt increments.
- Release occurs on a transfer with o_last = 1, or on a transfer where MAX_BEATS != 0 and cnt+1 == MAX_BEATS. On release:
  - next state IDLE
  - ptr = o_sel+1 (mod 8)
  - o_gnt = 0 and o_sel = 0
- A granted requester may deassert i_req_vld mid-packet. The grant is held, and o_vld follows i_req_vld[o_sel].
- In IDLE: o_vld = 0, o_last = 0, o_req_rdy = 0.
- o_req_rdy and o_vld never depend on a non-granted requester's signals.
- Handshake rules: a requester must hold its data and last stable while valid is high and not accepted. Downstream may toggle i_rdy freely.

## Timing
- Reset values: state IDLE, ptr 0, cnt 0, o_sel 0, o_gnt 0, o_busy 0, o_vld 0, o_last 0, o_req_rdy 0.
- Reset has priority over every event, including mid-packet. The granted packet is abandoned, with no further o_req_rdy in the cycle after reset.
- Grant latency: request visible in IDLE at cycle N; o_gnt/o_sel/o_busy valid at N+1; first transfer possible at N+1.
- Single-beat packet: the earliest transfer is N+1. Back in IDLE at N+2, the next grant is visible at N+3. There is one arbitration bubble cycle between packets.
- o_sel changes only on the clock edge that enters BUSY or IDLE. It is stable for the whole grant, so the mux slices see no select glitch during a transfer.
- Simultaneous requests: the winner depends only on ptr, never on arrival order.
- The requester just released has the lowest priority in the next arbitration.
- ptr wrap: after granting 7, ptr = 0.
- cnt is 16 bits and never exceeds MAX_BEATS-1 when the limit is enabled. With MAX_BEATS = 0, cnt wraps freely and is ignored.
- A last and a limit hit in the same beat cause a single release, not a double advance.

## Test plan
- Reset then single request: i_req_vld=8'h10 at cycle 2, i_rdy=1, last on first beat → o_gnt=8'h10 and o_sel=4 at cycle 3; o_req_rdy=8'h10 at cycle 3; IDLE at cycle 4; ptr=5.
- Round-robin fairness: all eight requesters valid continuously, 1-beat packets → grant order 0,1,…,7,0 with exactly one bubble cycle between grants; no requester granted twice in 8 grants.
- Backpressure and withdrawal: grant requester 2 with a 4-beat packet; i_rdy pattern 1,0,0,1,1,1; requester drops valid in one cycle → exactly 4 transfers; o_sel stays 2 throughout; release only after the beat with last.
- Beat limit: MAX_BEATS=3, requester 6 streams 10 beats with no last, requester 1 also valid → release after beat 3; next grant goes to requester 1 (ptr=7, wrap); requester 6 re-granted afterwards.
- Reset mid-packet: reset asserted during beat 2 of a 5-beat packet from requester 3 → next cycle o_gnt=0, o_busy=0, o_req_rdy=0; after reset, with all valid, the first grant goes to requester 0.
- Random regression: random valid/last/i_rdy on all eight requesters for 10k cycles; the scoreboard checks one-hot o_req_rdy, packet integrity per grant, and bounded wait ≤ 7 packets per requester.
